alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational `alu` instance (32-bit operands a/b, 4-bit aluop, 32-bit result) between NUM_REQ independent requesters.
- Round-robin arbitration; one operation issued per cycle.
- Result is registered into a single-entry response slot tagged with the requester ID.
- Sits between the decode/issue logic of multiple clients (e.g. core pipeline, address-gen, debug unit) and the shared ALU.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; NUM_REQ <= 2**ID_W required.
- DATA_W, 32, operand/result width; fixed at 32 to match `alu`.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operation valid.
- req_ready  output  NUM_REQ  per-requester accept (one-hot or zero).
- req_a  input  NUM_REQ*32  packed operand A; requester i at [32*i+31:32*i].
- req_b  input  NUM_REQ*32  packed operand B, same packing.
- req_aluop  input  NUM_REQ*4  packed opcode; requester i at [4*i+3:4*i].
- resp_valid  output  1  response slot full.
- resp_ready  input  1  consumer accepts response.
- resp_id  output  ID_W  requester index of current response.
- resp_result  output  32  registered ALU result.

Behaviour:
- Reset (async, rst=1): resp_valid=0, resp_id=0, resp_result=0, rr_ptr=0 (requester 0 highest priority), state=EMPTY. req_ready is combinational and therefore 0 while rst=1.
- Slot FSM has two states:
  - EMPTY: resp_valid=0.
  - FULL: resp_valid=1.
- Transitions:
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on resp_ready with no grant.
  - FULL -> FULL on resp_ready with a grant (back-to-back).
  - FULL stays FULL, holding its contents, when resp_ready=0.
- can_issue = (state==EMPTY) | resp_ready.
- Grant is issued only when can_issue=1 and at least one req_valid is set.
- Winner is the first set req_valid scanning from rr_ptr upward, modulo NUM_REQ.
- req_ready is combinational and one-hot on the winner; all zeros when there is no grant.
- A handshake occurs when req_valid[i] & req_ready[i]. Requesters hold valid and payload stable until accepted. Deasserting valid before acceptance is allowed (request withdrawn, no side effect).
- Winner's a/b/aluop are muxed to the `alu`. On the grant edge: resp_result <= alu result, resp_id <= winner index, rr_ptr <= (winner+1) mod NUM_REQ.
- Latency: accept in cycle N -> resp_valid=1 in cycle N+1.
- Throughput: 1 op/cycle while resp_ready=1.
- Backpressure: resp_ready=0 in FULL -> req_ready all 0; resp_id/resp_result stable.
- rr_ptr is unchanged in any cycle without a grant.
- Single requester active: served every cycle regardless of rr_ptr.
- Wrap-around: winner NUM_REQ-1 -> rr_ptr=0.
- Indices >= NUM_REQ are unused; ID arithmetic is modulo NUM_REQ, not 2**ID_W.
- Reset mid-operation drops the in-flight response; no request is considered accepted in a cycle where rst=1.
- The block is opcode-agnostic: aluop is passed through unmodified and arithmetic width/overflow follows `alu` (32-bit wrap).

Optional Feature:
- Macro: ALU_ARB_ZERO_FLAG_EN.
- Defined: adds output resp_zero (1 bit), registered with resp_result. resp_zero=1 iff the ALU result == 32'd0. Reset value 0; held with the slot under backpressure.
- Undefined: port absent, no extra logic.

Test Plan:
- Single op: req_valid=4'b0001, a=11, b=3, aluop=4'b0000 (add) -> req_ready=4'b0001 same cycle; next cycle resp_valid=1, resp_id=0, resp_result=14.
- Round-robin: all four valid continuously, resp_ready=1, rr_ptr=0 after reset -> grants 0,1,2,3,0 on consecutive cycles; resp_id follows one cycle later; no bubbles.
- Backpressure: slot FULL with result 14, resp_ready=0 for 3 cycles with requester 2 valid -> req_ready=0, resp_result stays 14. Drop resp_ready to 1 -> requester 2 granted that cycle, its result appears next cycle.
- Wrap/skip: rr_ptr=3, only req_valid[1] set -> requester 1 granted; rr_ptr becomes 2.
- Async reset: assert rst mid-stream while resp_valid=1 -> resp_valid, resp_id, resp_result go to 0 immediately, without waiting for a clock edge. After release, the first grant goes to the lowest-index valid requester.
- ALU_ARB_ZERO_FLAG_EN: a=3, b=3, aluop=4'b0010 (sub, assuming the `alu` encoding uses 0010 for subtract) -> resp_result=0, resp_zero=1. Add 11+3 -> resp_zero=0.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter (with combinational sub-module alu)
// Description : Round-robin sharing of one ALU between NUM_REQ requesters,
//               with a single registered, ID-tagged response slot.
//               Optional macro ALU_ARB_ZERO_FLAG_EN adds output resp_zero.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*4-1:0]      req_aluop,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [ID_W-1:0]           resp_id,
    output logic [DATA_W-1:0]         resp_result
`ifdef ALU_ARB_ZERO_FLAG_EN
    ,
    output logic                      resp_zero
`endif
);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam int c_PAD_W = 2 ** ID_W;

    state_t              state_q,       state_d;
    logic [ID_W-1:0]     rr_ptr_q,      rr_ptr_d;
    logic [ID_W-1:0]     resp_id_q,     resp_id_d;
    logic [DATA_W-1:0]   resp_result_q, resp_result_d;

    logic [c_PAD_W-1:0]  w_valid_pad;
    logic [ID_W:0]       w_scan;
    logic                w_found;
    logic [ID_W-1:0]     w_win_idx;
    logic                w_can_issue;
    logic                w_grant;
    logic [DATA_W-1:0]   w_op_a;
    logic [DATA_W-1:0]   w_op_b;
    logic [3:0]          w_op_code;
    logic [DATA_W-1:0]   w_alu_result;

    // Padding to a power of two lets the ID-wide scan index select directly;
    // the pad bits are always zero so unused IDs can never win.
    always_comb begin
        w_valid_pad                = '0;
        w_valid_pad[NUM_REQ-1:0]   = req_valid;
    end

    // Scan from rr_ptr upward, wrapping modulo NUM_REQ (not 2**ID_W).
    always_comb begin
        w_found   = 1'b0;
        w_win_idx = '0;
        w_scan    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (w_scan >= (ID_W+1)'(NUM_REQ)) begin
                w_scan = w_scan - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && w_valid_pad[w_scan[ID_W-1:0]]) begin
                w_found   = 1'b1;
                w_win_idx = w_scan[ID_W-1:0];
            end
        end
    end

    assign w_can_issue = (state_q == S_EMPTY) || resp_ready;
    assign w_grant     = w_found && w_can_issue && !rst;

    always_comb begin
        req_ready = '0;
        w_op_a    = '0;
        w_op_b    = '0;
        w_op_code = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win_idx == ID_W'(i)) begin
                req_ready[i] = w_grant;
                w_op_a       = req_a[DATA_W*i +: DATA_W];
                w_op_b       = req_b[DATA_W*i +: DATA_W];
                w_op_code    = req_aluop[4*i +: 4];
            end
        end
    end

    alu u_alu (
        .a      (w_op_a),
        .b      (w_op_b),
        .aluop  (w_op_code),
        .result (w_alu_result)
    );

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        resp_id_d     = resp_id_q;
        resp_result_d = resp_result_q;
        if (w_grant) begin
            state_d       = S_FULL;
            resp_id_d     = w_win_idx;
            resp_result_d = w_alu_result;
            if (w_win_idx == ID_W'(NUM_REQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = w_win_idx + ID_W'(1);
            end
        end else if (state_q == S_FULL && resp_ready) begin
            state_d = S_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_EMPTY;
            rr_ptr_q      <= '0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
        end
    end

    assign resp_valid  = (state_q == S_FULL);
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;

`ifdef ALU_ARB_ZERO_FLAG_EN
    logic resp_zero_q, resp_zero_d;

    // Captured alongside the result so it follows the slot under backpressure.
    always_comb begin
        resp_zero_d = resp_zero_q;
        if (w_grant) begin
            resp_zero_d = (w_alu_result == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_zero_q <= 1'b0;
        end else begin
            resp_zero_q <= resp_zero_d;
        end
    end

    assign resp_zero = resp_zero_q;
`endif

endmodule

// ============================================================================
// Module      : alu
// Description : 32-bit combinational ALU shared by alu_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  aluop,
    output logic [31:0] result
);

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_SLL  = 4'b0001;
    localparam logic [3:0] c_OP_SUB  = 4'b0010;
    localparam logic [3:0] c_OP_SLT  = 4'b0011;
    localparam logic [3:0] c_OP_XOR  = 4'b0100;
    localparam logic [3:0] c_OP_SRL  = 4'b0101;
    localparam logic [3:0] c_OP_OR   = 4'b0110;
    localparam logic [3:0] c_OP_AND  = 4'b0111;
    localparam logic [3:0] c_OP_SLTU = 4'b1000;
    localparam logic [3:0] c_OP_SRA  = 4'b1001;
    localparam logic [3:0] c_OP_PASB = 4'b1010;

    always_comb begin
        result = a;
        case (aluop)
            c_OP_ADD:  result = a + b;
            c_OP_SLL:  result = a << b[4:0];
            c_OP_SUB:  result = a - b;
            c_OP_SLT:  result = {31'd0, $signed(a) < $signed(b)};
            c_OP_XOR:  result = a ^ b;
            c_OP_SRL:  result = a >> b[4:0];
            c_OP_OR:   result = a | b;
            c_OP_AND:  result = a & b;
            c_OP_SLTU: result = {31'd0, a < b};
            c_OP_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            c_OP_PASB: result = b;
            default:   result = a;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Scoreboard bench for alu_arbiter; directed vectors with
//               hand-computed results. Honours ALU_ARB_ZERO_FLAG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int DW      = 32;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*DW-1:0]   req_a;
    logic [NUM_REQ*DW-1:0]   req_b;
    logic [NUM_REQ*4-1:0]    req_aluop;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [ID_W-1:0]         resp_id;
    logic [DW-1:0]           resp_result;
`ifdef ALU_ARB_ZERO_FLAG_EN
    logic                    resp_zero;
`endif

    alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DATA_W(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_aluop   (req_aluop),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result)
`ifdef ALU_ARB_ZERO_FLAG_EN
        ,
        .resp_zero   (resp_zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [DW-1:0]   res;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every consumed response is compared against the oldest expectation.
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got id %0d result 0x%0h, expected none", resp_id, resp_result);
            end else begin
                mon_e = sb.pop_front();
                check("resp_id", resp_id, mon_e.id);
                check("resp_result", resp_result, mon_e.res);
`ifdef ALU_ARB_ZERO_FLAG_EN
                check("resp_zero", resp_zero, (mon_e.res == 0));
`endif
            end
        end
    end

    // One cycle of stimulus: drive after posedge, check grant/slot at negedge,
    // and queue the hand-computed response of an expected grant.
    task automatic issue(input logic [NUM_REQ-1:0] mask, input logic rr,
                         input logic [NUM_REQ-1:0] exp_ready, input logic exp_rv,
                         input logic [ID_W-1:0] exp_id, input logic [DW-1:0] exp_res,
                         input string tag);
        @(posedge clk); #1;
        req_valid  = mask;
        resp_ready = rr;
        @(negedge clk);
        check({tag, "_req_ready"}, req_ready, exp_ready);
        check({tag, "_resp_valid"}, resp_valid, exp_rv);
        if (exp_ready != '0) sb.push_back('{exp_id, exp_res});
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    initial begin
        rst        = 1'b1;
        req_valid  = '1;
        resp_ready = 1'b0;
        // r0: 11+3=14, r1: 100-58=42, r2: FFFFFFFF+1=0 (wrap), r3: F0^FF0=F00
        req_a      = {32'h0000_00F0, 32'hFFFF_FFFF, 32'd100, 32'd11};
        req_b      = {32'h0000_0FF0, 32'd1,         32'd58,  32'd3};
        req_aluop  = {4'b0100,       4'b0000,       4'b0010, 4'b0000};

        @(negedge clk);
        @(negedge clk);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_resp_result", resp_result, 0);
        check("rst_req_ready", req_ready, 0);
        req_valid = '0;
        rst       = 1'b0;

        issue(4'b0001, 1, 4'b0001, 0, 0, 32'd14, "single");
        issue(4'b0000, 1, 4'b0000, 1, 0, 32'd0,  "single_lat");

        do_reset();
        issue(4'b1111, 1, 4'b0001, 0, 0, 32'd14,  "rr0");
        issue(4'b1111, 1, 4'b0010, 1, 1, 32'd42,  "rr1");
        issue(4'b1111, 1, 4'b0100, 1, 2, 32'd0,   "rr2");
        issue(4'b1111, 1, 4'b1000, 1, 3, 32'hF00, "rr3");
        issue(4'b1111, 1, 4'b0001, 1, 0, 32'd14,  "rr4");

        for (int i = 0; i < 3; i++) begin
            issue(4'b0100, 0, 4'b0000, 1, 0, 32'd0, "bp");
            check("bp_result_hold", resp_result, 32'd14);
            check("bp_id_hold", resp_id, 0);
        end
        issue(4'b0100, 1, 4'b0100, 1, 2, 32'd0, "bp_release");
        issue(4'b0000, 1, 4'b0000, 1, 0, 32'd0, "bp_drain");

        // rr_ptr is now 3: skip to requester 1, then confirm pointer moved to 2
        issue(4'b0010, 1, 4'b0010, 0, 1, 32'd42,  "skip");
        issue(4'b1111, 1, 4'b0100, 1, 2, 32'd0,   "ptr2");
        issue(4'b1111, 1, 4'b1000, 1, 3, 32'hF00, "wrap3");
        issue(4'b1010, 1, 4'b0010, 1, 1, 32'd42,  "after_wrap");

        for (int i = 0; i < 3; i++) begin
            issue(4'b1000, 1, 4'b1000, 1, 3, 32'hF00, "only3");
        end

        @(posedge clk); #1;
        req_valid  = '0;
        resp_ready = 1'b0;
        #1;
        check("pre_rst_valid", resp_valid, 1);
        check("pre_rst_id", resp_id, 3);
        rst = 1'b1;
        #1;
        check("async_rst_valid", resp_valid, 0);
        check("async_rst_id", resp_id, 0);
        check("async_rst_result", resp_result, 0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        issue(4'b0110, 1, 4'b0010, 0, 1, 32'd42, "post_rst");
        issue(4'b0000, 1, 4'b0000, 1, 0, 32'd0,  "post_rst_drain");

`ifdef ALU_ARB_ZERO_FLAG_EN
        req_a[31:0]     = 32'd3;
        req_b[31:0]     = 32'd3;
        req_aluop[3:0]  = 4'b0010;
        issue(4'b0001, 1, 4'b0001, 0, 0, 32'd0, "zero_sub");
        @(posedge clk); #1;
        req_valid      = '0;
        req_a[31:0]    = 32'd11;
        req_aluop[3:0] = 4'b0000;
        @(negedge clk);
        check("zero_flag_set", resp_zero, 1);
        issue(4'b0001, 1, 4'b0001, 0, 0, 32'd14, "zero_add");
        issue(4'b0000, 1, 4'b0000, 1, 0, 32'd0,  "zero_drain");
        check("zero_flag_clear", resp_zero, 0);
`endif

        repeat (2) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
